// File: rtl/bp_nd_mux_socket.sv
// bp_nd_mux_socket
//   Tile-side wormhole socket. Several tile channels share one network link.
//   TX: packet-locked round-robin mux of els_p channels into a two-entry
//       output buffer that drives the link from registers only.
//   RX: steers each incoming packet to a per-channel FIFO by the channel id in
//       its header flit. Packets with an out-of-range id are dropped, and the
//       sticky bad_chan_o flag is set.
//
// Ports
//   clk_i, reset_n_i                 clock, asynchronous active-low reset
//   tile_v_i / tile_data_i           per-channel TX flits (ready/valid)
//   tile_ready_and_o                 per-channel TX accept
//   net_v_o / net_data_o             link TX flit
//   net_ready_and_i                  link TX ready
//   net_v_i / net_data_i             link RX flit
//   net_ready_and_o                  link RX ready
//   tile_v_o / tile_data_o           per-channel RX FIFO head
//   tile_yumi_i                      per-channel RX consume (only while valid)
//   bad_chan_o                       sticky: RX header with out-of-range channel
//
// Optional build macro BP_ND_MUX_SOCKET_PERF_EN adds the following ports:
//   tx_stall_cnt_o [31:0]            cycles with net_v_o=1 and net_ready_and_i=0
//   rx_pkt_cnt_o   [els_p*16-1:0]    per-channel count of headers steered
//   Both counters saturate at all-ones.

module bp_nd_mux_socket
  #(parameter int flit_width_p  = 16  // no natural default; set per link
   ,parameter int els_p         = 2
   ,parameter int len_width_p   = 4
   ,parameter int len_lsb_p     = 0
   ,parameter int chan_lsb_p    = 4
   ,parameter int rx_fifo_els_p = 2
   )
  (input  logic                            clk_i
  ,input  logic                            reset_n_i
  ,input  logic [els_p-1:0]                tile_v_i
  ,input  logic [els_p*flit_width_p-1:0]   tile_data_i
  ,output logic [els_p-1:0]                tile_ready_and_o
  ,output logic                            net_v_o
  ,output logic [flit_width_p-1:0]         net_data_o
  ,input  logic                            net_ready_and_i
  ,input  logic                            net_v_i
  ,input  logic [flit_width_p-1:0]         net_data_i
  ,output logic                            net_ready_and_o
  ,output logic [els_p-1:0]                tile_v_o
  ,output logic [els_p*flit_width_p-1:0]   tile_data_o
  ,input  logic [els_p-1:0]                tile_yumi_i
  ,output logic                            bad_chan_o
`ifdef BP_ND_MUX_SOCKET_PERF_EN
  ,output logic [31:0]                     tx_stall_cnt_o
  ,output logic [els_p*16-1:0]             rx_pkt_cnt_o
`endif
  );

  localparam int chan_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int ptr_w_lp  = (rx_fifo_els_p > 1) ? $clog2(rx_fifo_els_p) : 1;
  localparam int cnt_w_lp  = $clog2(rx_fifo_els_p + 1);

  // ---------------------------------------------------------------- TX path
  typedef enum logic {TX_IDLE, TX_LOCKED} tx_state_e;

  tx_state_e               tx_state_reg, tx_state_next;
  logic [chan_w_lp-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [chan_w_lp-1:0]    tx_chan_reg, tx_chan_next;
  logic [len_width_p-1:0]  tx_cnt_reg, tx_cnt_next;
  logic [chan_w_lp-1:0]    tx_sel;
  logic                    tx_go;
  logic [flit_width_p-1:0] tx_flit;
  logic [len_width_p-1:0]  tx_len;
  int                      idx;

  logic [flit_width_p-1:0] obuf_mem [2];
  logic [1:0]              obuf_cnt_reg;
  logic                    obuf_wr_reg, obuf_rd_reg;
  logic                    obuf_not_full, obuf_deq;

  // Ready to tiles depends only on buffer occupancy (a register), never on
  // net_ready_and_i, so the link has no combinational path back to the tiles.
  assign obuf_not_full = (obuf_cnt_reg != 2'd2);

  // Round-robin: scan from the highest offset down so the lowest offset from
  // the pointer with a valid request is the last (winning) assignment.
  always_comb begin
    tx_sel = tx_chan_reg;
    tx_go  = 1'b0;
    idx    = 0;
    if (tx_state_reg == TX_IDLE) begin
      for (int i = els_p-1; i >= 0; i--) begin
        idx = int'(rr_ptr_reg) + i;
        if (idx >= els_p) idx = idx - els_p;
        if (tile_v_i[idx]) begin
          tx_sel = chan_w_lp'(idx);
          tx_go  = 1'b1;
        end
      end
    end else begin
      tx_go = tile_v_i[tx_chan_reg];
    end
    tx_go = tx_go & obuf_not_full;
  end

  for (genvar gi = 0; gi < els_p; gi++) begin : g_tx_ready
    assign tile_ready_and_o[gi] = tx_go & (int'(tx_sel) == gi);
  end

  assign tx_flit = tile_data_i[tx_sel*flit_width_p +: flit_width_p];
  assign tx_len  = tx_flit[len_lsb_p +: len_width_p];

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_chan_next  = tx_chan_reg;
    tx_cnt_next   = tx_cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    if (tx_go) begin
      if (tx_state_reg == TX_IDLE) begin
        rr_ptr_next = (int'(tx_sel) == els_p-1) ? '0 : tx_sel + 1'b1;
        if (tx_len != '0) begin
          tx_state_next = TX_LOCKED;
          tx_chan_next  = tx_sel;
          tx_cnt_next   = tx_len;
        end
      end else begin
        tx_cnt_next = tx_cnt_reg - 1'b1;
        if (tx_cnt_reg == len_width_p'(1)) tx_state_next = TX_IDLE;
      end
    end
  end

  assign obuf_deq = net_v_o & net_ready_and_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state_reg <= TX_IDLE;
      tx_chan_reg  <= '0;
      tx_cnt_reg   <= '0;
      rr_ptr_reg   <= '0;
      obuf_cnt_reg <= '0;
      obuf_wr_reg  <= 1'b0;
      obuf_rd_reg  <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_chan_reg  <= tx_chan_next;
      tx_cnt_reg   <= tx_cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
      if (tx_go)    obuf_wr_reg <= ~obuf_wr_reg;
      if (obuf_deq) obuf_rd_reg <= ~obuf_rd_reg;
      obuf_cnt_reg <= obuf_cnt_reg + {1'b0, tx_go} - {1'b0, obuf_deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_go) obuf_mem[obuf_wr_reg] <= tx_flit;
  end

  assign net_v_o    = (obuf_cnt_reg != 2'd0);
  assign net_data_o = obuf_mem[obuf_rd_reg];

  // ---------------------------------------------------------------- RX path
  typedef enum logic [1:0] {RX_IDLE, RX_STEER, RX_DROP} rx_state_e;

  rx_state_e              rx_state_reg, rx_state_next;
  logic [chan_w_lp-1:0]   rx_chan_reg, rx_chan_next;
  logic [len_width_p-1:0] rx_cnt_reg, rx_cnt_next;
  logic                   bad_chan_reg, bad_chan_next;
  logic [chan_w_lp-1:0]   hdr_chan, rx_tgt;
  logic [len_width_p-1:0] hdr_len;
  logic                   hdr_ok, rx_keep, rx_take;
  logic [els_p-1:0]       rx_tgt_oh, fifo_full, fifo_wr;

  assign hdr_chan = net_data_i[chan_lsb_p +: chan_w_lp];
  assign hdr_len  = net_data_i[len_lsb_p +: len_width_p];
  assign hdr_ok   = (int'(hdr_chan) < els_p);
  assign rx_tgt   = (rx_state_reg == RX_IDLE) ? hdr_chan : rx_chan_reg;
  // Flit is destined for a FIFO (as opposed to being discarded).
  assign rx_keep  = (rx_state_reg == RX_STEER) | ((rx_state_reg == RX_IDLE) & hdr_ok);

  for (genvar gi = 0; gi < els_p; gi++) begin : g_rx_sel
    assign rx_tgt_oh[gi] = (int'(rx_tgt) == gi);
    assign fifo_wr[gi]   = rx_take & rx_keep & rx_tgt_oh[gi];
  end

  // Discarded flits are always accepted; kept flits wait on their FIFO, which
  // stalls the whole link (accepted head-of-line blocking).
  assign net_ready_and_o = rx_keep ? |(rx_tgt_oh & ~fifo_full) : 1'b1;
  assign rx_take         = net_v_i & net_ready_and_o;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_chan_next  = rx_chan_reg;
    rx_cnt_next   = rx_cnt_reg;
    bad_chan_next = bad_chan_reg;
    if (rx_take) begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (hdr_ok) begin
            rx_chan_next = hdr_chan;
            if (hdr_len != '0) begin
              rx_state_next = RX_STEER;
              rx_cnt_next   = hdr_len;
            end
          end else begin
            bad_chan_next = 1'b1;
            if (hdr_len != '0) begin
              rx_state_next = RX_DROP;
              rx_cnt_next   = hdr_len;
            end
          end
        end
        default: begin
          rx_cnt_next = rx_cnt_reg - 1'b1;
          if (rx_cnt_reg == len_width_p'(1)) rx_state_next = RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_state_reg <= RX_IDLE;
      rx_chan_reg  <= '0;
      rx_cnt_reg   <= '0;
      bad_chan_reg <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_chan_reg  <= rx_chan_next;
      rx_cnt_reg   <= rx_cnt_next;
      bad_chan_reg <= bad_chan_next;
    end
  end

  assign bad_chan_o = bad_chan_reg;

  for (genvar gi = 0; gi < els_p; gi++) begin : g_rx_fifo
    logic [flit_width_p-1:0] mem [rx_fifo_els_p];
    logic [ptr_w_lp-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [cnt_w_lp-1:0]     cnt_reg;

    assign fifo_full[gi] = (cnt_reg == cnt_w_lp'(rx_fifo_els_p));

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        cnt_reg    <= '0;
      end else begin
        if (fifo_wr[gi])
          wr_ptr_reg <= (wr_ptr_reg == ptr_w_lp'(rx_fifo_els_p-1)) ? '0 : wr_ptr_reg + 1'b1;
        if (tile_yumi_i[gi])
          rd_ptr_reg <= (rd_ptr_reg == ptr_w_lp'(rx_fifo_els_p-1)) ? '0 : rd_ptr_reg + 1'b1;
        cnt_reg <= cnt_reg + cnt_w_lp'(fifo_wr[gi]) - cnt_w_lp'(tile_yumi_i[gi]);
      end
    end

    always_ff @(posedge clk_i) begin
      if (fifo_wr[gi]) mem[wr_ptr_reg] <= net_data_i;
    end

    assign tile_v_o[gi]                                  = (cnt_reg != '0);
    assign tile_data_o[gi*flit_width_p +: flit_width_p]  = mem[rd_ptr_reg];

`ifdef BP_ND_MUX_SOCKET_PERF_EN
    logic [15:0] pkt_cnt_reg;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
        pkt_cnt_reg <= '0;
      else if (fifo_wr[gi] && (rx_state_reg == RX_IDLE) && (pkt_cnt_reg != '1))
        pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
    end
    assign rx_pkt_cnt_o[gi*16 +: 16] = pkt_cnt_reg;
`endif
  end

`ifdef BP_ND_MUX_SOCKET_PERF_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      tx_stall_cnt_o <= '0;
    else if (net_v_o && !net_ready_and_i && (tx_stall_cnt_o != '1))
      tx_stall_cnt_o <= tx_stall_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_bp_nd_mux_socket.sv
// Directed bench for bp_nd_mux_socket (3 channels, 16-bit flits, RX FIFO depth 4).
// Header flit layout: {tag[7:0], 2'b00, chan[1:0], len[3:0]}.
module tb_bp_nd_mux_socket;
  localparam int W = 16;
  localparam int N = 3;

  logic             clk = 1'b0;
  logic             reset_n_i = 1'b1;
  logic [N-1:0]     tile_v_i = '0;
  logic [N*W-1:0]   tile_data_i = '0;
  logic [N-1:0]     tile_ready_and_o;
  logic             net_v_o;
  logic [W-1:0]     net_data_o;
  logic             net_ready_and_i = 1'b1;
  logic             net_v_i = 1'b0;
  logic [W-1:0]     net_data_i = '0;
  logic             net_ready_and_o;
  logic [N-1:0]     tile_v_o;
  logic [N*W-1:0]   tile_data_o;
  logic [N-1:0]     tile_yumi_i = '0;
  logic             bad_chan_o;
`ifdef BP_ND_MUX_SOCKET_PERF_EN
  logic [31:0]      tx_stall_cnt_o;
  logic [N*16-1:0]  rx_pkt_cnt_o;
`endif

  always #5 clk = ~clk;

  bp_nd_mux_socket #(
    .flit_width_p(W), .els_p(N), .len_width_p(4), .len_lsb_p(0),
    .chan_lsb_p(4), .rx_fifo_els_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .tile_v_i(tile_v_i), .tile_data_i(tile_data_i), .tile_ready_and_o(tile_ready_and_o),
    .net_v_o(net_v_o), .net_data_o(net_data_o), .net_ready_and_i(net_ready_and_i),
    .net_v_i(net_v_i), .net_data_i(net_data_i), .net_ready_and_o(net_ready_and_o),
    .tile_v_o(tile_v_o), .tile_data_o(tile_data_o), .tile_yumi_i(tile_yumi_i),
    .bad_chan_o(bad_chan_o)
`ifdef BP_ND_MUX_SOCKET_PERF_EN
    , .tx_stall_cnt_o(tx_stall_cnt_o), .rx_pkt_cnt_o(rx_pkt_cnt_o)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [W-1:0] tx_src [N][$];   // per-channel flits still to offer
  logic [W-1:0] exp_tx [$];      // expected link output order
  logic [W-1:0] rx_src_d [$];    // link flits still to offer
  int           rx_src_dst [$];  // destination channel per link flit, -1 = dropped
  logic [W-1:0] rx_exp [N][$];   // expected per-channel RX output
  int           tx_acc = 0;
  int           tx_out = 0;
  logic         yumi_en = 1'b0;
  logic         lock_watch = 1'b0;

  function automatic logic [W-1:0] mk(input logic [7:0] tag, input logic [1:0] chan,
                                      input logic [3:0] len);
    return {tag, 2'b00, chan, len};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rx(input logic [W-1:0] d, input int dst);
    rx_src_d.push_back(d);
    rx_src_dst.push_back(dst);
  endtask

  function automatic logic busy();
    logic b;
    b = (exp_tx.size() != 0) || (rx_src_d.size() != 0);
    for (int c = 0; c < N; c++)
      b = b || (tx_src[c].size() != 0) || (rx_exp[c].size() != 0);
    return b;
  endfunction

  task automatic clear_all();
    for (int c = 0; c < N; c++) begin
      tx_src[c].delete();
      rx_exp[c].delete();
    end
    exp_tx.delete();
    rx_src_d.delete();
    rx_src_dst.delete();
    tx_acc = 0;
    tx_out = 0;
  endtask

  // One clock: drive from the source queues at the falling edge, settle,
  // score every handshake that will complete at the coming rising edge.
  task automatic step();
    logic [W-1:0] e;
    int           dst;
    for (int c = 0; c < N; c++) begin
      tile_v_i[c]          = (tx_src[c].size() != 0);
      tile_data_i[c*W +: W] = (tx_src[c].size() != 0) ? tx_src[c][0] : '0;
    end
    net_v_i     = (rx_src_d.size() != 0);
    net_data_i  = (rx_src_d.size() != 0) ? rx_src_d[0] : '0;
    tile_yumi_i = tile_v_o & {N{yumi_en}};
    #1;
    if (lock_watch && tx_src[0].size() != 0)
      chk("lock_ready1", tile_ready_and_o[1], 1'b0);
    if (net_v_o && net_ready_and_i) begin
      chk("tx_pending", exp_tx.size() != 0, 1'b1);
      if (exp_tx.size() != 0) begin
        e = exp_tx.pop_front();
        chk("tx_data", net_data_o, e);
      end
      tx_out++;
    end
    for (int c = 0; c < N; c++) begin
      if (tile_v_i[c] && tile_ready_and_o[c]) begin
        void'(tx_src[c].pop_front());
        tx_acc++;
      end
    end
    if (net_v_i && net_ready_and_o) begin
      e   = rx_src_d.pop_front();
      dst = rx_src_dst.pop_front();
      if (dst >= 0) rx_exp[dst].push_back(e);
    end
    for (int c = 0; c < N; c++) begin
      if (tile_yumi_i[c]) begin
        chk("rx_pending", rx_exp[c].size() != 0, 1'b1);
        if (rx_exp[c].size() != 0) begin
          e = rx_exp[c].pop_front();
          chk("rx_data", tile_data_o[c*W +: W], e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy() && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, busy(), 1'b0);
  endtask

  task automatic do_reset();
    clear_all();
    tile_v_i = '0; net_v_i = 1'b0; tile_yumi_i = '0;
    reset_n_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    #1 reset_n_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_net_v", net_v_o, 1'b0);
    chk("rst_tile_v", tile_v_o, 3'b000);
    chk("rst_bad", bad_chan_o, 1'b0);
    chk("rst_ready", tile_ready_and_o, 3'b000);
    @(negedge clk);
    reset_n_i = 1'b1;
    @(negedge clk);

    // Lock: ch0 4-flit packet stays contiguous while ch1 waits.
    tx_src[0].push_back(mk(8'hA0, 2'd0, 4'd3));
    tx_src[0].push_back(16'hA1B1);
    tx_src[0].push_back(16'hA2B2);
    tx_src[0].push_back(16'hA3B3);
    tx_src[1].push_back(mk(8'hC0, 2'd1, 4'd0));
    exp_tx.push_back(mk(8'hA0, 2'd0, 4'd3));
    exp_tx.push_back(16'hA1B1);
    exp_tx.push_back(16'hA2B2);
    exp_tx.push_back(16'hA3B3);
    exp_tx.push_back(mk(8'hC0, 2'd1, 4'd0));
    lock_watch = 1'b1;
    drain("lock_drain", 30);
    lock_watch = 1'b0;

    // Fairness: pointer at 0, one flit per cycle after a 1-cycle fill.
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < N; c++) begin
        tx_src[c].push_back(mk(8'h10 + 8'(c*16 + k), 2'(c), 4'd0));
        exp_tx.push_back(mk(8'h10 + 8'(c*16 + k), 2'(c), 4'd0));
      end
    step();
    chk("fair_v_rise", net_v_o, 1'b1);
    n = 1;
    while (exp_tx.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("fair_cycles", n, 10);

    // Backpressure mid-packet; ch1 must wait for the whole ch0 packet.
    tx_src[0].push_back(mk(8'hD0, 2'd0, 4'd5));
    exp_tx.push_back(mk(8'hD0, 2'd0, 4'd5));
    for (int k = 1; k < 6; k++) begin
      tx_src[0].push_back(16'hD000 + 16'(k));
      exp_tx.push_back(16'hD000 + 16'(k));
    end
    tx_src[1].push_back(mk(8'hE0, 2'd1, 4'd0));
    exp_tx.push_back(mk(8'hE0, 2'd1, 4'd0));
    step();
    step();
    net_ready_and_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_occupancy", (tx_acc - tx_out) <= 2, 1'b1);
      if (i >= 1) chk("bp_ready", tile_ready_and_o, 3'b000);
    end
    net_ready_and_i = 1'b1;
    drain("bp_drain", 40);

    // RX steering, consumer held off to observe occupancy and latency.
    push_rx(mk(8'h11, 2'd1, 4'd2), 1);
    push_rx(16'h1201, 1);
    push_rx(16'h1302, 1);
    push_rx(mk(8'h21, 2'd0, 4'd0), 0);
    chk("rx_v_pre", tile_v_o, 3'b000);
    step();
    chk("rx_v_latency", tile_v_o, 3'b010);
    repeat (3) step();
    chk("rx_v_both", tile_v_o, 3'b011);
    chk("rx_fifo1_cnt", rx_exp[1].size(), 3);
    chk("rx_fifo0_cnt", rx_exp[0].size(), 1);
    yumi_en = 1'b1;
    drain("rx_drain", 20);
    chk("rx_empty", tile_v_o, 3'b000);

    // Bad channel: chan 3 packet dropped, chan 0 packet delivered.
    chk("bad_pre", bad_chan_o, 1'b0);
    push_rx(mk(8'h31, 2'd3, 4'd2), -1);
    push_rx(16'h3201, -1);
    push_rx(16'h3302, -1);
    push_rx(mk(8'h41, 2'd0, 4'd1), 0);
    push_rx(16'h4201, 0);
    drain("bad_drain", 40);
    chk("bad_set", bad_chan_o, 1'b1);
    chk("bad_no_leak", tile_v_o, 3'b000);
    repeat (5) step();
    chk("bad_sticky", bad_chan_o, 1'b1);

    // Reset mid-packet: TX locked on ch0, RX steering to ch1.
    yumi_en = 1'b0;
    net_ready_and_i = 1'b0;
    tx_src[0].push_back(mk(8'h51, 2'd0, 4'd5));
    for (int k = 1; k < 6; k++) tx_src[0].push_back(16'h5200 + 16'(k));
    push_rx(mk(8'h61, 2'd1, 4'd3), 1);
    push_rx(16'h6201, 1);
    repeat (3) step();
    chk("pre_rst_net_v", net_v_o, 1'b1);
    chk("pre_rst_tile_v", tile_v_o, 3'b010);
    clear_all();
    tile_v_i = '0; net_v_i = 1'b0; tile_yumi_i = '0;
    #2 reset_n_i = 1'b0;
    #1;
    chk("async_rst_net_v", net_v_o, 1'b0);
    chk("async_rst_tile_v", tile_v_o, 3'b000);
    chk("async_rst_bad", bad_chan_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n_i = 1'b1;
    net_ready_and_i = 1'b1;
    yumi_en = 1'b1;
    tx_src[2].push_back(mk(8'h72, 2'd2, 4'd0));
    tx_src[1].push_back(mk(8'h71, 2'd1, 4'd0));
    tx_src[0].push_back(mk(8'h70, 2'd0, 4'd0));
    exp_tx.push_back(mk(8'h70, 2'd0, 4'd0));
    exp_tx.push_back(mk(8'h71, 2'd1, 4'd0));
    exp_tx.push_back(mk(8'h72, 2'd2, 4'd0));
    push_rx(mk(8'h81, 2'd0, 4'd0), 0);
    drain("rst_resume", 30);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
